// File: rtl/rob_pkg.sv
// Shared core definitions used by the ROB and the RAT.
// Provides the default machine sizes and the per-entry status struct.
// The status struct contains no width-dependent fields, so it stays correct
// when a block overrides the size parameters. Destination and result fields
// are kept in separate parameterized arrays inside the ROB.
package rob_pkg;

    localparam int CORE_ROB_DEPTH      = 8;
    localparam int CORE_GPR_ADDR_WIDTH = 5;
    localparam int CORE_DATA_WIDTH     = 32;

    typedef struct packed {
        logic valid;
        logic done;
        logic dst_wen;
        logic br_taken;
        logic exp;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer used for the ROB head and tail.
// The pointer is TW+1 bits wide. The MSB flips on each wrap, so equal
// indices with different wrap bits mean the buffer is full.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the pointer to zero (has priority over inc)
//   inc        : advance the pointer by one
//   ptr        : current pointer value, {wrap, index}
module rob_ptr #(
    parameter int TW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [TW:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + (TW+1)'(1);
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer for the out-of-order core.
// Tags are allocated in program order and the allocate side of the RAT is
// driven from them. Writeback results arrive out of order and are recorded
// against their tag. Entries retire in order, one per cycle, and drive the
// RAT and the GPR file on retire. When a retiring entry is a taken branch or
// has an exception, the ROB flushes everything at the end of that cycle.
// Ports:
//   alloc_*                     : dispatch request, destination, alloc_ready
//   allocate_en, rob_alloc_*    : RAT allocate strobe, tag and passthroughs
//   wb_*                        : execution-unit writeback
//   rs1_*/rs2_*                 : combinational operand lookup by tag
//   commit_dst_en, rob_commit_* : retiring entry; all zero when none retires
module rob
    import rob_pkg::*;
#(
    parameter  int ROB_DEPTH      = CORE_ROB_DEPTH,
    parameter  int GPR_ADDR_WIDTH = CORE_GPR_ADDR_WIDTH,
    parameter  int DATA_WIDTH     = CORE_DATA_WIDTH,
    localparam int TW             = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // allocate
    input  logic                      alloc_req,
    input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
    input  logic                      alloc_dst_wen,
    output logic                      alloc_ready,
    output logic                      allocate_en,
    output logic [TW-1:0]             rob_alloc_tag_2rat,
    output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
    output logic                      rob_alloc_dst_wen_2rat,
    // writeback
    input  logic                      wb_en,
    input  logic [TW-1:0]             wb_tag,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_br_taken,
    input  logic                      wb_exp,
    // operand lookup
    input  logic [TW-1:0]             rs1_tag,
    input  logic [TW-1:0]             rs2_tag,
    output logic                      rs1_done,
    output logic                      rs2_done,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    // commit
    output logic                      commit_dst_en,
    output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
    output logic [TW-1:0]             rob_commit_Paddr,
    output logic [DATA_WIDTH-1:0]     rob_commit_data,
    output logic                      rob_commit_br_taken,
    output logic                      rob_commit_exp_en
);

    logic [TW:0]   head, tail;
    logic [TW-1:0] head_idx, tail_idx;

    rob_entry_t [ROB_DEPTH-1:0]                     ent;
    logic       [ROB_DEPTH-1:0][GPR_ADDR_WIDTH-1:0] dst_addr;
    logic       [ROB_DEPTH-1:0][DATA_WIDTH-1:0]     data;

    logic full, commit_fire, flush, wb_hit;

    assign head_idx = head[TW-1:0];
    assign tail_idx = tail[TW-1:0];

    assign full        = (head_idx == tail_idx) && (head[TW] != tail[TW]);
    assign commit_fire = ent[head_idx].valid & ent[head_idx].done;
    // Writebacks to entries that are not live (stale or never allocated) are dropped.
    assign wb_hit      = wb_en & ent[wb_tag].valid;

    // ---------------- commit side ----------------
    assign commit_dst_en            = commit_fire & ent[head_idx].dst_wen;
    assign rob_commit_dst_addr_2rat = commit_fire ? dst_addr[head_idx] : '0;
    assign rob_commit_Paddr         = commit_fire ? head_idx : '0;
    assign rob_commit_data          = commit_fire ? data[head_idx] : '0;
    assign rob_commit_br_taken      = commit_fire & ent[head_idx].br_taken;
    assign rob_commit_exp_en        = commit_fire & ent[head_idx].exp;

    assign flush = rob_commit_br_taken | rob_commit_exp_en;

    // ---------------- allocate side ----------------
    // A slot freed by this cycle's commit only becomes usable next cycle.
    // This keeps alloc_ready independent of the commit decision.
    assign alloc_ready             = !full & !flush;
    assign allocate_en             = alloc_req & alloc_ready;
    assign rob_alloc_tag_2rat      = tail_idx;
    assign rob_alloc_dst_addr_2rat = alloc_dst_addr;
    assign rob_alloc_dst_wen_2rat  = alloc_dst_wen;

    // ---------------- operand lookup ----------------
    assign rs1_done = ent[rs1_tag].valid & ent[rs1_tag].done;
    assign rs2_done = ent[rs2_tag].valid & ent[rs2_tag].done;
    assign rs1_data = rs1_done ? data[rs1_tag] : '0;
    assign rs2_data = rs2_done ? data[rs2_tag] : '0;

    // ---------------- pointers ----------------
    rob_ptr #(.TW(TW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (commit_fire & !flush),
        .ptr   (head)
    );

    rob_ptr #(.TW(TW)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (allocate_en),
        .ptr   (tail)
    );

    // ---------------- entry state ----------------
    // A commit and an allocation cannot target the same slot. A valid head
    // at the tail index means the buffer is full, and that blocks the
    // allocation. A writeback cannot hit the slot being allocated, because
    // that slot is still invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent      <= '0;
            dst_addr <= '0;
            data     <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done  <= 1'b0;
            end
        end else begin
            if (wb_hit) begin
                ent[wb_tag].done     <= 1'b1;
                ent[wb_tag].br_taken <= wb_br_taken;
                ent[wb_tag].exp      <= wb_exp;
                data[wb_tag]         <= wb_data;
            end
            if (commit_fire)
                ent[head_idx].valid <= 1'b0;
            if (allocate_en) begin
                ent[tail_idx].valid    <= 1'b1;
                ent[tail_idx].done     <= 1'b0;
                ent[tail_idx].dst_wen  <= alloc_dst_wen;
                ent[tail_idx].br_taken <= 1'b0;
                ent[tail_idx].exp      <= 1'b0;
                dst_addr[tail_idx]     <= alloc_dst_addr;
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob.
// The reference model treats the ROB as a program-order queue of
// instructions. Each instruction's tag is its allocation count modulo
// DEPTH, counted since the last flush or reset. The checker evaluates the
// model against the DUT on every falling edge, then advances the model.
// The driver issues directed scenarios followed by random traffic.
module tb_rob;

    localparam int DEPTH = 8;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int TW    = 3;

    logic          clk, rst_n;
    logic          alloc_req, alloc_dst_wen;
    logic [AW-1:0] alloc_dst_addr;
    logic          alloc_ready, allocate_en;
    logic [TW-1:0] rob_alloc_tag_2rat;
    logic [AW-1:0] rob_alloc_dst_addr_2rat;
    logic          rob_alloc_dst_wen_2rat;
    logic          wb_en, wb_br_taken, wb_exp;
    logic [TW-1:0] wb_tag;
    logic [DW-1:0] wb_data;
    logic [TW-1:0] rs1_tag, rs2_tag;
    logic          rs1_done, rs2_done;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          commit_dst_en;
    logic [AW-1:0] rob_commit_dst_addr_2rat;
    logic [TW-1:0] rob_commit_Paddr;
    logic [DW-1:0] rob_commit_data;
    logic          rob_commit_br_taken, rob_commit_exp_en;

    rob dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_dst_addr(alloc_dst_addr), .alloc_dst_wen(alloc_dst_wen),
        .alloc_ready(alloc_ready), .allocate_en(allocate_en),
        .rob_alloc_tag_2rat(rob_alloc_tag_2rat), .rob_alloc_dst_addr_2rat(rob_alloc_dst_addr_2rat),
        .rob_alloc_dst_wen_2rat(rob_alloc_dst_wen_2rat),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .wb_br_taken(wb_br_taken), .wb_exp(wb_exp),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_done(rs1_done), .rs2_done(rs2_done),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .commit_dst_en(commit_dst_en), .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
        .rob_commit_Paddr(rob_commit_Paddr), .rob_commit_data(rob_commit_data),
        .rob_commit_br_taken(rob_commit_br_taken), .rob_commit_exp_en(rob_commit_exp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        logic [AW-1:0] dst;
        bit          wen;
        bit          done;
        logic [DW-1:0] data;
        bit          br;
        bit          ex;
    } mrec_t;

    mrec_t         rob_q[$];
    int            next_tag;
    logic [AW-1:0] commit_log[$];

    function automatic int find(input int tag);
        foreach (rob_q[i]) if (rob_q[i].tag == tag) return i;
        return -1;
    endfunction

    mrec_t         h, nr, t;
    bit            cf, fl, ar, ae;
    int            i1, i2, iw;
    bit            e1d, e2d;
    logic [DW-1:0] e1v, e2v;

    always @(negedge clk) begin
        if (!rst_n) begin
            rob_q.delete();
            next_tag = 0;
        end else begin
            cf = 0;
            h  = '{default: 0};
            if (rob_q.size() > 0 && rob_q[0].done) begin
                cf = 1;
                h  = rob_q[0];
            end
            fl = cf && (h.br || h.ex);
            ar = (rob_q.size() < DEPTH) && !fl;
            ae = alloc_req && ar;

            i1 = find(int'(rs1_tag));
            i2 = find(int'(rs2_tag));
            e1d = (i1 >= 0) && rob_q[i1].done;
            e2d = (i2 >= 0) && rob_q[i2].done;
            e1v = e1d ? rob_q[i1].data : '0;
            e2v = e2d ? rob_q[i2].data : '0;

            chk("alloc_ready", 64'(alloc_ready), 64'(ar));
            chk("allocate_en", 64'(allocate_en), 64'(ae));
            chk("alloc_tag", 64'(rob_alloc_tag_2rat), 64'(next_tag));
            chk("alloc_dst_pass", 64'(rob_alloc_dst_addr_2rat), 64'(alloc_dst_addr));
            chk("alloc_wen_pass", 64'(rob_alloc_dst_wen_2rat), 64'(alloc_dst_wen));
            chk("commit_dst_en", 64'(commit_dst_en), 64'(cf && h.wen));
            chk("commit_dst_addr", 64'(rob_commit_dst_addr_2rat), 64'(cf ? h.dst : '0));
            chk("commit_paddr", 64'(rob_commit_Paddr), 64'(cf ? h.tag : 0));
            chk("commit_data", 64'(rob_commit_data), 64'(cf ? h.data : '0));
            chk("commit_br", 64'(rob_commit_br_taken), 64'(cf && h.br));
            chk("commit_exp", 64'(rob_commit_exp_en), 64'(cf && h.ex));
            chk("rs1_done", 64'(rs1_done), 64'(e1d));
            chk("rs1_data", 64'(rs1_data), 64'(e1v));
            chk("rs2_done", 64'(rs2_done), 64'(e2d));
            chk("rs2_data", 64'(rs2_data), 64'(e2v));

            if (cf) commit_log.push_back(rob_commit_dst_addr_2rat);

            // advance the model to the state after the coming edge
            if (fl) begin
                rob_q.delete();
                next_tag = 0;
            end else begin
                iw = find(int'(wb_tag));
                if (wb_en && iw >= 0) begin
                    t      = rob_q[iw];
                    t.done = 1;
                    t.data = wb_data;
                    t.br   = wb_br_taken;
                    t.ex   = wb_exp;
                    rob_q[iw] = t;
                end
                if (cf) void'(rob_q.pop_front());
                if (ae) begin
                    nr = '{tag: next_tag, dst: alloc_dst_addr, wen: alloc_dst_wen,
                           done: 0, data: '0, br: 0, ex: 0};
                    rob_q.push_back(nr);
                    next_tag = (next_tag + 1) % DEPTH;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle();
        alloc_req = 0; alloc_dst_addr = '0; alloc_dst_wen = 0;
        wb_en = 0; wb_tag = '0; wb_data = '0; wb_br_taken = 0; wb_exp = 0;
        rs1_tag = '0; rs2_tag = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input int dst, input bit wen);
        alloc_req = 1; alloc_dst_addr = AW'(dst); alloc_dst_wen = wen;
    endtask

    task automatic wb(input int tag, input logic [DW-1:0] d, input bit br, input bit ex);
        wb_en = 1; wb_tag = TW'(tag); wb_data = d; wb_br_taken = br; wb_exp = ex;
    endtask

    // Asserts reset while idle, checks reset values, and releases it after a
    // falling edge (the model clears itself there).
    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        chk("rst_allocate_en", 64'(allocate_en), 64'(0));
        chk("rst_alloc_tag", 64'(rob_alloc_tag_2rat), 64'(0));
        chk("rst_commit_en", 64'(commit_dst_en), 64'(0));
        chk("rst_commit_paddr", 64'(rob_commit_Paddr), 64'(0));
        chk("rst_commit_data", 64'(rob_commit_data), 64'(0));
        chk("rst_commit_flush", 64'({rob_commit_br_taken, rob_commit_exp_en}), 64'(0));
        chk("rst_rs_done", 64'({rs1_done, rs2_done}), 64'(0));
        chk("rst_rs_data", 64'(rs1_data | rs2_data), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        commit_log.delete();
    endtask

    int cand[$];

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // in-order retirement of out-of-order writebacks
        alloc(1, 1); step();
        alloc(2, 1); step();
        alloc(3, 1); step();
        wb(2, 32'h2222, 0, 0); step();
        wb(0, 32'h0000_1000, 0, 0); step();
        wb(1, 32'h1111, 0, 0); step();
        repeat (4) step();
        chk("order_count", 64'(commit_log.size()), 64'(3));
        if (commit_log.size() == 3) begin
            chk("order_0", 64'(commit_log[0]), 64'(1));
            chk("order_1", 64'(commit_log[1]), 64'(2));
            chk("order_2", 64'(commit_log[2]), 64'(3));
        end

        // fill to full, then free one slot
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(i + 4, 1); step();
        end
        alloc(20, 1); #1;
        chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
        chk("full_allocate_en", 64'(allocate_en), 64'(0));
        step();
        wb(0, 32'hA5A5_0000, 0, 0); step();
        #1;
        chk("full_commit_ready", 64'(alloc_ready), 64'(0));
        chk("full_commit_fire", 64'(commit_dst_en), 64'(1));
        step();
        alloc(21, 1); #1;
        chk("refill_ready", 64'(alloc_ready), 64'(1));
        chk("refill_tag", 64'(rob_alloc_tag_2rat), 64'(0));
        step();

        // wrap-around triplets
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc(i, 1); step();
            wb(i % DEPTH, DW'(32'h100 + i), 0, 0); step();
            step();
        end

        // exception flush with a dropped allocation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(10 + i, 1); step();
        end
        wb(1, 32'hE0E0, 0, 1); step();
        wb(0, 32'h0F0F, 0, 0); step();
        step();
        alloc(30, 1); #1;
        chk("flush_exp", 64'(rob_commit_exp_en), 64'(1));
        chk("flush_paddr", 64'(rob_commit_Paddr), 64'(1));
        chk("flush_ready", 64'(alloc_ready), 64'(0));
        chk("flush_drop", 64'(allocate_en), 64'(0));
        step();
        rs1_tag = 2; rs2_tag = 0; #1;
        chk("post_flush_ready", 64'(alloc_ready), 64'(1));
        chk("post_flush_tag", 64'(rob_alloc_tag_2rat), 64'(0));
        step();

        // operand lookup
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc(i + 1, 1); step();
        end
        wb(2, 32'hDEADBEEF, 0, 0); step();
        rs1_tag = 2; rs2_tag = 5; #1;
        chk("lookup_rs1_done", 64'(rs1_done), 64'(1));
        chk("lookup_rs1_data", 64'(rs1_data), 64'(32'hDEADBEEF));
        chk("lookup_rs2_done", 64'(rs2_done), 64'(0));
        chk("lookup_rs2_data", 64'(rs2_data), 64'(0));
        step();

        // non-writing entry and writeback to an invalid tag
        do_reset();
        alloc(7, 0); step();
        wb(6, 32'h6666, 1, 1); step();
        rs1_tag = 6; #1;
        chk("bad_wb_done", 64'(rs1_done), 64'(0));
        wb(0, 32'h1234, 0, 0); step();
        #1;
        chk("nowen_commit_en", 64'(commit_dst_en), 64'(0));
        chk("nowen_commit_data", 64'(rob_commit_data), 64'(32'h1234));
        step();
        alloc(8, 1); #1;
        chk("nowen_next_tag", 64'(rob_alloc_tag_2rat), 64'(1));
        step();

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 9) < 6) alloc(int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6) begin
                cand.delete();
                foreach (rob_q[i]) if (!rob_q[i].done) cand.push_back(rob_q[i].tag);
                if (cand.size() > 0 && $urandom_range(0, 4) != 0)
                    wb(cand[$urandom_range(0, cand.size() - 1)], $urandom,
                       $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
                else
                    wb(int'($urandom_range(0, DEPTH - 1)), $urandom, 0, 0);
            end
            rs1_tag = TW'($urandom_range(0, DEPTH - 1));
            rs2_tag = TW'($urandom_range(0, DEPTH - 1));
            step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order core. It allocates ROB tags (physical addresses) to renamed instructions in program order and drives the allocate side of the register alias table. It collects out-of-order writeback results and retires entries in order, driving the RAT and the GPR file on commit. A committed taken branch or exception flushes the whole machine.

## Interface
Parameters:
- ROB_DEPTH, 8, number of entries; power of two, at least 2.
- GPR_ADDR_WIDTH, 5, architectural register address width.
- DATA_WIDTH, 32, result width.
- TW, $clog2(ROB_DEPTH), tag width (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- alloc_req  in  1  dispatch requests one entry.
- alloc_dst_addr  in  GPR_ADDR_WIDTH  destination architectural register.
- alloc_dst_wen  in  1  instruction writes a GPR.
- alloc_ready  out  1  an entry can be accepted this cycle.
- allocate_en  out  1  alloc_req & alloc_ready (RAT allocate strobe).
- rob_alloc_tag_2rat  out  TW  tag given to the allocating instruction (tail index).
- rob_alloc_dst_addr_2rat  out  GPR_ADDR_WIDTH  passthrough of alloc_dst_addr.
- rob_alloc_dst_wen_2rat  out  1  passthrough of alloc_dst_wen.
- wb_en  in  1  execution-unit result valid.
- wb_tag  in  TW  entry being completed.
- wb_data  in  DATA_WIDTH  result.
- wb_br_taken  in  1  the instruction is a mispredicted or taken redirect.
- wb_exp  in  1  the instruction raised an exception.
- rs1_tag, rs2_tag  in  TW  operand lookup tags from RAT.
- rs1_done, rs2_done  out  1  the looked-up entry is valid and has completed.
- rs1_data, rs2_data  out  DATA_WIDTH  the looked-up entry's result.
- commit_dst_en  out  1  a GPR-writing entry retires this cycle.
- rob_commit_dst_addr_2rat  out  GPR_ADDR_WIDTH  destination of the retiring entry.
- rob_commit_Paddr  out  TW  tag of the retiring entry (head index).
- rob_commit_data  out  DATA_WIDTH  result to the GPR file.
- rob_commit_br_taken  out  1  the retiring entry is a taken branch; triggers flush.
- rob_commit_exp_en  out  1  the retiring entry has an exception; triggers flush.

## Operation
- Per-entry state: valid, done, dst_addr, dst_wen, data, br_taken, exp.
- Pointers head and tail are TW+1 bits wide; the MSB is a wrap bit.
  - empty = head == tail.
  - full = index bits equal and wrap bits differ.
- commit_fire = valid[head] & done[head]. At most one entry retires per cycle.
  - On commit_fire, all commit outputs reflect the head entry. commit_dst_en = commit_fire & dst_wen. rob_commit_br_taken and rob_commit_exp_en are qualified by commit_fire.
  - When commit_fire is low, all commit outputs are 0.
- flush = rob_commit_br_taken | rob_commit_exp_en.
- alloc_ready = !full & !flush.
- On allocate_en: write entry[tail] with valid=1, done=0 and the destination fields; tail increments.
- On wb_en with valid[wb_tag]: set done, data, br_taken and exp. A writeback to an invalid entry is ignored.
- On commit_fire without flush: clear valid[head]; head increments.
- On flush: clear every valid and done bit; head=tail=0. Any same-cycle allocate or writeback is discarded.
- Operand lookups are combinational:
  - rsN_done = valid[rsN_tag] & done[rsN_tag].
  - rsN_data = data[rsN_tag], or 0 when rsN_done is 0.
- Simultaneous allocate and commit when not full: both take effect. When full, alloc_ready is 0 even if the head commits that cycle.

## Timing
- Reset: all entries invalid; head=tail=0; alloc_ready=1; every other output 0.
- Allocation tag is valid combinationally in the request cycle. The entry exists from the next edge.
- A writeback at edge N makes the entry committable, and visible on rsN_done, in cycle N+1.
- Commit outputs are combinational from registered state: zero cycles after done is set, the retire takes effect at the next edge.
- Flush takes effect at the edge ending the flushing commit cycle. The ROB is empty in the next cycle.
- Reset asserted mid-operation returns all state to reset values immediately.

## Structure
- ROB_DEPTH, GPR_ADDR_WIDTH and DATA_WIDTH come from the shared core defines package, the same one the RAT uses.
- The entry-field struct belongs in the shared package.
- One natural sub-module: rob_ptr, a wrap-bit pointer with increment and clear, instantiated for head and tail.

## Test plan
- Allocate 3 entries (dst x1, x2, x3) -> tags 0, 1, 2. Writeback in order 2, 0, 1 -> commits in order 0, 1, 2 in the cycles after each head becomes done. rob_commit_dst_addr_2rat sequence is 1, 2, 3.
- Allocate 8 entries with no writeback -> alloc_ready=0 after the 8th. An alloc_req in the 9th cycle gives allocate_en=0. Writeback and commit tag 0 -> alloc_ready=1 the following cycle, and the new tag is 0.
- Wrap-around: run 20 alloc/wb/commit triplets -> tags cycle 0..7. full and empty are never falsely flagged across the wrap.
- Allocate tags 0..3; writeback tag 1 with wb_exp=1, then tag 0 normal. Tag 0 commits, then tag 1 commits with rob_commit_exp_en=1 -> next cycle all entries invalid, head=tail=0, alloc_ready=1. An alloc_req during the flush cycle is dropped.
- Writeback tag 2 with data 0xDEADBEEF -> rs1_tag=2 gives rs1_done=1 and rs1_data=0xDEADBEEF next cycle. rs2_tag pointing at an unallocated entry gives rs2_done=0 and rs2_data=0.
- Entry with alloc_dst_wen=0 commits -> commit_dst_en=0 and head advances. A writeback to an invalid tag leaves state unchanged.
